// File: rtl/as_alu_pkg.sv
// Shared constants and types for the as_alu datapath slice.
// Optional feature: AS_ALU_MULT_ROUND_EN (round-half-up fractional multiply).
package as_alu_pkg;

  localparam int unsigned AS_ALU_N_DEFAULT    = 8;
  localparam int unsigned AS_ALU_FRAC_DEFAULT = AS_ALU_N_DEFAULT - 1;

  // Fraction bits of the Q1.(width-1) immediate used by the multiplier.
  function automatic int unsigned frac_bits(input int unsigned width);
    return width - 1;
  endfunction

  typedef enum logic [1:0] {
    RD  = 2'd0,
    SW8 = 2'd1,
    ACC = 2'd2
  } add_a_sel_e;

endpackage

// File: rtl/as_alu_mult.sv
// Signed fractional multiplier: rs_data * Q1.(n-1) immediate, rescaled to n bits.
// With AS_ALU_MULT_ROUND_EN defined the product is rounded half up, else truncated.
module as_alu_mult
  import as_alu_pkg::*;
#(
  parameter int unsigned n = AS_ALU_N_DEFAULT
) (
  input  logic [n-1:0] rs_data,
  input  logic [n-1:0] immediate,
  output logic [n-1:0] mult_out
);

  localparam int unsigned FRAC = frac_bits(n);

  logic signed [2*n-1:0] product;
  logic signed [2*n-1:0] adjusted;

  always_comb begin
    product = $signed(rs_data) * $signed(immediate);
`ifdef AS_ALU_MULT_ROUND_EN
    adjusted = product + $signed({{(n+1){1'b0}}, 1'b1, {(n-2){1'b0}}});
`else
    adjusted = product;
`endif
    // Arithmetic shift keeps bits [2n-2:n-1] in the low n positions.
    mult_out = n'(adjusted >>> FRAC);
  end

endmodule

// File: rtl/as_alu.sv
// Accumulator ALU: operand muxes, adder, zero flag, writeback mux and ACC register.
// Optional feature: AS_ALU_MULT_ROUND_EN (passed through to as_alu_mult).
module as_alu
  import as_alu_pkg::*;
#(
  parameter int unsigned n = AS_ALU_N_DEFAULT
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [n-1:0] rd_data,
  input  logic [n-1:0] rs_data,
  input  logic [n-1:0] immediate,
  input  logic         add_a_sel,
  input  logic         add_b_sel,
  input  logic [8:0]   switches,
  input  logic         acc_en,
  input  logic         acc_add,
  input  logic         in_en,
  output logic         z,
  output logic [n-1:0] w_data,
  output logic [n-1:0] acc_out
);

  logic [n-1:0] mult_out;
  logic [n-1:0] add_out;
  logic [n-1:0] add_a;
  logic [n-1:0] add_b;
  logic [n-1:0] sw_ext;
  add_a_sel_e   a_sel;

  as_alu_mult #(.n(n)) u_mult (
    .rs_data   (rs_data),
    .immediate (immediate),
    .mult_out  (mult_out)
  );

  always_comb begin
    if (acc_add)        a_sel = ACC;
    else if (add_a_sel) a_sel = SW8;
    else                a_sel = RD;
  end

  // ACC feeds the adder from the register output, so MACC sees the pre-edge value.
  always_comb begin
    add_a = rd_data;
    unique case (a_sel)
      ACC:     add_a = acc_out;
      SW8:     add_a = {n{switches[8]}};
      default: add_a = rd_data;
    endcase
  end

  always_comb begin
    add_b   = add_b_sel ? immediate : mult_out;
    add_out = add_a + add_b;
    z       = (add_out == '0);
  end

  always_comb begin
    sw_ext      = '0;
    sw_ext[7:0] = switches[7:0];
    w_data      = in_en ? sw_ext : add_out;
  end

  always_ff @(posedge clk) begin
    if (!n_reset)    acc_out <= '0;
    else if (acc_en) acc_out <= add_out;
  end

endmodule

// File: tb/tb_as_alu.sv
// Self-checking bench for as_alu: directed scenarios plus randomized runs
// against an integer-arithmetic reference model.
module tb_as_alu;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         n_reset;
  logic [N-1:0] rd_data, rs_data, immediate;
  logic         add_a_sel, add_b_sel;
  logic [8:0]   switches;
  logic         acc_en, acc_add, in_en;
  logic         z;
  logic [N-1:0] w_data, acc_out;

  int errors = 0;
  int checks = 0;
  int model_acc = 0;

  as_alu #(.n(N)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .rd_data   (rd_data),
    .rs_data   (rs_data),
    .immediate (immediate),
    .add_a_sel (add_a_sel),
    .add_b_sel (add_b_sel),
    .switches  (switches),
    .acc_en    (acc_en),
    .acc_add   (acc_add),
    .in_en     (in_en),
    .z         (z),
    .w_data    (w_data),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fixed-point product rescaled by 2^(N-1), floor division on plain integers.
  function automatic int ref_mult(input logic [N-1:0] a, input logic [N-1:0] b);
    int sa, sb, p;
    sa = (a >= 128) ? int'(a) - 256 : int'(a);
    sb = (b >= 128) ? int'(b) - 256 : int'(b);
    p  = sa * sb;
`ifdef AS_ALU_MULT_ROUND_EN
    p  = p + 64;
`endif
    p  = (p >= 0) ? p / 128 : -((-p + 127) / 128);
    return p & 255;
  endfunction

  function automatic int ref_add(input int acc);
    int a, b;
    if (acc_add)        a = acc;
    else if (add_a_sel) a = switches[8] ? 255 : 0;
    else                a = int'(rd_data);
    b = add_b_sel ? int'(immediate) : ref_mult(rs_data, immediate);
    return (a + b) % 256;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_data = '0; rs_data = '0; immediate = '0; switches = '0;
    add_a_sel = 0; add_b_sel = 0; acc_en = 0; acc_add = 0; in_en = 0;
  endtask

  initial begin
    int exp_add;
    idle();
    n_reset = 0;
    tick();
    check("reset_acc", 32'(acc_out), 0);
    n_reset = 1;

    // Constant load
    add_b_sel = 1; acc_en = 1; rd_data = 0; rs_data = 23; immediate = 6;
    #1;
    check("load_add", 32'(dut.add_out), 6);
    tick();
    check("load_acc", 32'(acc_out), 6);

    // MACC with 0.75
    acc_add = 1; add_b_sel = 0; rs_data = 20; immediate = 8'b0110_0000;
    #1;
    check("macc_mult", 32'(dut.mult_out), 15);
    check("macc_add", 32'(dut.add_out), 21);
    tick();
    check("macc_acc", 32'(acc_out), 21);

    // Writeback mux
    idle();
    add_b_sel = 1; rd_data = 12; immediate = 8; switches = 9'd30;
    #1;
    check("wb_add", 32'(w_data), 20);
    in_en = 1;
    #1;
    check("wb_sw", 32'(w_data), 30);

    // Zero flag via sign-extended SW[8]
    idle();
    add_a_sel = 1; rs_data = 0; immediate = 8'h55;
    #1;
    check("zero_add", 32'(dut.add_out), 0);
    check("zero_z", 32'(z), 1);
    switches = 9'h100;
    #1;
    check("neg_add", 32'(dut.add_out), 8'hFF);
    check("neg_z", 32'(z), 0);

    // Reset overrides acc_en; combinational outputs still live
    idle();
    check("pre_rst_acc", 32'(acc_out), 21);
    n_reset = 0; acc_en = 1; add_b_sel = 1; immediate = 5;
    #1;
    check("rst_wdata", 32'(w_data), 5);
    check("rst_z", 32'(z), 0);
    tick();
    check("rst_acc", 32'(acc_out), 0);
    n_reset = 1; acc_en = 0;
    tick();
    check("hold_acc", 32'(acc_out), 0);

    // Signed multiply and rounding boundary
    idle();
    rs_data = 8'hEC; immediate = 8'b0110_0000;
    #1;
    check("smul_add", 32'(dut.add_out), 8'hF1);
    rs_data = 3; immediate = 8'b0100_0000;
    #1;
`ifdef AS_ALU_MULT_ROUND_EN
    check("half_mult", 32'(dut.mult_out), 2);
`else
    check("half_mult", 32'(dut.mult_out), 1);
`endif

    // Randomized run against the reference model
    model_acc = 0;
    n_reset = 0; tick(); n_reset = 1;
    for (int i = 0; i < 300; i++) begin
      rd_data   = N'($urandom);
      rs_data   = N'($urandom);
      immediate = N'($urandom);
      switches  = 9'($urandom);
      add_a_sel = 1'($urandom);
      add_b_sel = 1'($urandom);
      acc_add   = 1'($urandom);
      acc_en    = 1'($urandom);
      in_en     = 1'($urandom);
      n_reset   = ($urandom_range(0, 15) != 0);
      #1;
      exp_add = ref_add(model_acc);
      check("rnd_mult", 32'(dut.mult_out), 32'(ref_mult(rs_data, immediate)));
      check("rnd_add", 32'(dut.add_out), 32'(exp_add));
      check("rnd_z", 32'(z), 32'(exp_add == 0));
      check("rnd_wdata", 32'(w_data), in_en ? 32'(switches[7:0]) : 32'(exp_add));
      if (!n_reset)    model_acc = 0;
      else if (acc_en) model_acc = exp_add;
      tick();
      check("rnd_acc", 32'(acc_out), 32'(model_acc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
